// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared direction/mode encodings and the load clipping helper
//               for the parametrised up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Direction encodings for the 'up' input
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Boundary-behaviour encodings for the 'sat_mode' input
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Clamp a requested load value to the terminal count. Operands are carried
    // at 32 bits so one helper serves every counter width up to 32.
    function automatic logic [31:0] clip_to_max(input logic [31:0] val,
                                                 input logic [31:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/param_updown_counter_dff_bank.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank
// Description : WIDTH-bit D flip-flop bank with synchronous active-low reset
//               to RST_VAL. Holds the counter value; all next-state decisions
//               are made by the instantiating module.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank #(
    parameter int WIDTH   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_q;

    // Capture the next value every edge; reset (low) forces the reset value
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= c_rst_val;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : dff_bank
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_updown_counter
// Description : Parametrised up/down counter spanning 0..MAX_VAL with
//               parallel load, count enable, wrap or saturate at the limits,
//               a registered wrap pulse and zero-latency limit flags.
//               Optional feature macro: CNT_OVF_STICKY_EN enables the sticky
//               overflow/underflow flag; without it ovf_sticky reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_load_clip;
    logic             w_wrap_next;
    logic             w_boundary;
    logic             w_is_max;
    logic             w_is_zero;
    logic             r_wrap;

    // Count value storage
    dff_bank #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_dff_bank (
        .clk (clk),
        .rst (rst),
        .i_d (w_q_next),
        .o_q (w_q)
    );

    assign w_is_max    = (w_q == c_max);
    assign w_is_zero   = (w_q == c_zero);
    assign w_load_clip = WIDTH'(clip_to_max(32'(load_val), 32'(MAX_VAL)));

    // Next count: load beats enable; limits are compared against MAX_VAL so
    // a non-power-of-two modulus never relies on natural binary rollover.
    always_comb begin
        w_q_next    = w_q;
        w_wrap_next = 1'b0;
        w_boundary  = 1'b0;
        if (load) begin
            w_q_next = w_load_clip;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (w_is_max) begin
                    w_boundary = 1'b1;
                    if (sat_mode == MODE_WRAP) begin
                        w_q_next    = c_zero;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_q_next = w_q + c_one;
                end
            end else begin
                if (w_is_zero) begin
                    w_boundary = 1'b1;
                    if (sat_mode == MODE_WRAP) begin
                        w_q_next    = c_max;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_q_next = w_q - c_one;
                end
            end
        end
    end

    // One-cycle wrap pulse aligned with the wrapped count value
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

`ifdef CNT_OVF_STICKY_EN
    logic r_ovf;

    // Sticky boundary flag: a boundary event in the same cycle as a clear
    // keeps the flag set so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_boundary) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf;
`else
    // Feature disabled: flag tied low; clear input and event term are unused
    logic w_unused_ovf;
    assign w_unused_ovf = clr_ovf ^ w_boundary;
    assign ovf_sticky   = 1'b0;
`endif

    assign q       = w_q;
    assign wrap    = r_wrap;
    assign at_max  = w_is_max;
    assign at_zero = w_is_zero;

endmodule : param_updown_counter
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_updown_counter
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic against an integer reference model. Instance A is
//               WIDTH=4/MAX_VAL=9, instance B is WIDTH=8 with default modulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    localparam int MAXA = 9;
    localparam int MAXB = 255;
`ifdef CNT_OVF_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, up, sat_mode, load, clr_ovf;
    logic [3:0] load_val;
    logic [7:0] b_load_val;
    logic [3:0] q;
    logic       wrap, at_max, at_zero, ovf_sticky;
    logic [7:0] q2;
    logic       wrap2, at_max2, at_zero2, ovf_sticky2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_q, m2_q;
    bit m_wrap, m2_wrap, m_ovf, m2_ovf;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q), .wrap(wrap), .at_max(at_max), .at_zero(at_zero),
        .ovf_sticky(ovf_sticky)
    );

    param_updown_counter #(.WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode),
        .load(load), .load_val(b_load_val), .clr_ovf(clr_ovf),
        .q(q2), .wrap(wrap2), .at_max(at_max2), .at_zero(at_zero2),
        .ovf_sticky(ovf_sticky2)
    );

    always #5 clk = ~clk;

    // Behavioural rule set for one edge with reset released
    task automatic model_step(input int maxv, input int ldv, input int qin,
                              output int qout, output bit w, output bit ev);
        qout = qin;
        w    = 1'b0;
        ev   = 1'b0;
        if (load) begin
            qout = (ldv > maxv) ? maxv : ldv;
        end else if (en) begin
            if (up) begin
                if (qin + 1 > maxv) begin
                    ev   = 1'b1;
                    w    = !sat_mode;
                    qout = sat_mode ? maxv : 0;
                end else begin
                    qout = qin + 1;
                end
            end else begin
                if (qin - 1 < 0) begin
                    ev   = 1'b1;
                    w    = !sat_mode;
                    qout = sat_mode ? 0 : maxv;
                end else begin
                    qout = qin - 1;
                end
            end
        end
    endtask

    // Advance one clock, updating both models from the inputs being sampled
    task automatic tick();
        int nq, nq2;
        bit w, w2, ev, ev2;
        model_step(MAXA, int'(load_val), m_q, nq, w, ev);
        model_step(MAXB, int'(b_load_val), m2_q, nq2, w2, ev2);
        @(posedge clk);
        if (!rst) begin
            m_q = 0;  m_wrap = 0;  m_ovf = 0;
            m2_q = 0; m2_wrap = 0; m2_ovf = 0;
        end else begin
            m_q  = nq;  m_wrap  = w;
            m2_q = nq2; m2_wrap = w2;
            if (STICKY) begin
                if (ev) m_ovf = 1'b1; else if (clr_ovf) m_ovf = 1'b0;
                if (ev2) m2_ovf = 1'b1; else if (clr_ovf) m2_ovf = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5; b_load_val = 8'd77;
        up = 1'b1; sat_mode = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        n_vec++; if (q !== 4'd0) begin n_err++; $display("FAIL reset_q: got %0d want 0", q); end
        n_vec++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        n_vec++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_sticky); end
        n_vec++; if (at_zero !== 1'b1) begin n_err++; $display("FAIL reset_at_zero: got %b want 1", at_zero); end
        n_vec++; if (q2 !== 8'd0) begin n_err++; $display("FAIL reset_q2: got %0d want 0", q2); end
        rst = 1'b1; load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            int exp_q;
            exp_q = (i + 1) % 10;
            tick();
            n_vec++;
            if (q !== 4'(exp_q) || wrap !== (exp_q == 0)) begin
                n_err++;
                $display("FAIL up_run[%0d]: got q=%0d wrap=%b want q=%0d wrap=%b",
                         i, q, wrap, exp_q, (exp_q == 0));
            end
        end
    endtask

    task automatic test_down_wrap();
        load = 1'b1; load_val = 4'd0; en = 1'b0; clr_ovf = 1'b0;
        tick();
        load = 1'b0; up = 1'b0; en = 1'b1; sat_mode = 1'b0;
        tick();
        n_vec++; if (q !== 4'd9 || wrap !== 1'b1) begin n_err++;
            $display("FAIL down_wrap: got q=%0d wrap=%b want q=9 wrap=1", q, wrap); end
        n_vec++; if (at_max !== 1'b1) begin n_err++; $display("FAIL down_wrap_at_max: got %b want 1", at_max); end
        tick();
        n_vec++; if (q !== 4'd8 || wrap !== 1'b0) begin n_err++;
            $display("FAIL down_after_wrap: got q=%0d wrap=%b want q=8 wrap=0", q, wrap); end
    endtask

    task automatic test_saturate();
        sat_mode = 1'b1; load = 1'b1; load_val = 4'd8; en = 1'b0; clr_ovf = 1'b0;
        tick();
        load = 1'b0; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (q !== 4'd9 || wrap !== 1'b0 || at_max !== 1'b1) begin
                n_err++;
                $display("FAIL sat[%0d]: got q=%0d wrap=%b at_max=%b want q=9 wrap=0 at_max=1",
                         i, q, wrap, at_max);
            end
        end
        n_vec++; if (ovf_sticky !== STICKY) begin n_err++;
            $display("FAIL sat_ovf: got %b want %b", ovf_sticky, STICKY); end
        sat_mode = 1'b0;
    endtask

    task automatic test_load_clip();
        load = 1'b1; load_val = 4'd15; en = 1'b1; up = 1'b1;
        tick();
        n_vec++; if (q !== 4'd9 || wrap !== 1'b0) begin n_err++;
            $display("FAIL load_clip: got q=%0d wrap=%b want q=9 wrap=0", q, wrap); end
        load_val = 4'd3; up = 1'b0;
        tick();
        n_vec++; if (q !== 4'd3) begin n_err++; $display("FAIL load_priority: got %0d want 3", q); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_sticky();
        en = 1'b0; load = 1'b0; clr_ovf = 1'b1; sat_mode = 1'b0;
        tick();
        n_vec++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clear0: got %b want 0", ovf_sticky); end
        clr_ovf = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_vec++; if (q !== 4'd0 || wrap !== 1'b1 || ovf_sticky !== STICKY) begin n_err++;
            $display("FAIL sticky_set: got q=%0d wrap=%b ovf=%b want q=0 wrap=1 ovf=%b",
                     q, wrap, ovf_sticky, STICKY); end
        en = 1'b0; clr_ovf = 1'b1;
        tick();
        n_vec++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clear: got %b want 0", ovf_sticky); end
        clr_ovf = 1'b0; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1;
        tick();
        n_vec++; if (wrap !== 1'b1 || ovf_sticky !== STICKY) begin n_err++;
            $display("FAIL sticky_set_wins: got wrap=%b ovf=%b want wrap=1 ovf=%b",
                     wrap, ovf_sticky, STICKY); end
        clr_ovf = 1'b0; en = 1'b0;
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_val = 4'd6; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; rst = 1'b0;
        tick();
        n_vec++; if (q !== 4'd0 || wrap !== 1'b0 || ovf_sticky !== 1'b0) begin n_err++;
            $display("FAIL mid_reset: got q=%0d wrap=%b ovf=%b want 0 0 0", q, wrap, ovf_sticky); end
        rst = 1'b1;
        tick();
        n_vec++; if (q !== 4'd1) begin n_err++; $display("FAIL mid_reset_resume: got %0d want 1", q); end
    endtask

    task automatic test_wide();
        load = 1'b1; b_load_val = 8'd254; load_val = 4'd0; en = 1'b0; sat_mode = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_vec++; if (q2 !== 8'd255 || wrap2 !== 1'b0 || at_max2 !== 1'b1) begin n_err++;
            $display("FAIL wide_max: got q=%0d wrap=%b at_max=%b want 255 0 1", q2, wrap2, at_max2); end
        tick();
        n_vec++; if (q2 !== 8'd0 || wrap2 !== 1'b1 || at_zero2 !== 1'b1) begin n_err++;
            $display("FAIL wide_wrap: got q=%0d wrap=%b at_zero=%b want 0 1 1", q2, wrap2, at_zero2); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) != 0);
            en         = ($urandom_range(0, 3) != 0);
            up         = 1'($urandom);
            sat_mode   = ($urandom_range(0, 3) == 0);
            load       = ($urandom_range(0, 9) == 0);
            load_val   = 4'($urandom);
            b_load_val = 8'($urandom);
            clr_ovf    = ($urandom_range(0, 5) == 0);
            tick();
            n_vec++;
            if ({q, wrap, at_max, at_zero, ovf_sticky} !==
                {4'(m_q), m_wrap, (m_q == MAXA), (m_q == 0), m_ovf}) begin
                n_err++;
                $display("FAIL rand_a[%0d]: got q=%0d w=%b mx=%b z=%b o=%b want q=%0d w=%b mx=%b z=%b o=%b",
                         i, q, wrap, at_max, at_zero, ovf_sticky,
                         m_q, m_wrap, (m_q == MAXA), (m_q == 0), m_ovf);
            end
            n_vec++;
            if ({q2, wrap2, at_max2, at_zero2, ovf_sticky2} !==
                {8'(m2_q), m2_wrap, (m2_q == MAXB), (m2_q == 0), m2_ovf}) begin
                n_err++;
                $display("FAIL rand_b[%0d]: got q=%0d w=%b mx=%b z=%b o=%b want q=%0d w=%b mx=%b z=%b o=%b",
                         i, q2, wrap2, at_max2, at_zero2, ovf_sticky2,
                         m2_q, m2_wrap, (m2_q == MAXB), (m2_q == 0), m2_ovf);
            end
        end
    endtask

    initial begin
        m_q = 0; m2_q = 0; m_wrap = 0; m2_wrap = 0; m_ovf = 0; m2_ovf = 0;
        rst = 1'b0; en = 1'b0; up = 1'b1; sat_mode = 1'b0; load = 1'b0;
        clr_ovf = 1'b0; load_val = '0; b_load_val = '0;
        @(negedge clk);
        test_reset();
        test_down_wrap();
        test_saturate();
        test_load_clip();
        test_sticky();
        test_mid_reset();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_param_updown_counter
`default_nettype wire
